// File: rtl/nn_pkg.sv
// Shared constants and types for the nn_engine feature feeder.
// Holds the default frame geometry, result field widths, FSM encoding and result record.
package nn_pkg;

    localparam int unsigned N_FEAT  = 8;
    localparam int unsigned FEAT_W  = 8;
    localparam int unsigned CLASS_W = 2;
    localparam int unsigned CONF_W  = 8;
    localparam int unsigned SEQ_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StAck,
        StRun
    } feeder_state_e;

    typedef struct packed {
        logic [CLASS_W-1:0] cls;
        logic [CONF_W-1:0]  conf;
        logic [SEQ_W-1:0]   seq;
    } nn_result_t;

endpackage

// File: rtl/nn_result_fifo.sv
// Synchronous FIFO with an asynchronous active-low reset.
// A push while full is accepted only when a pop happens in the same cycle.
module nn_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 14
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/nn_feature_feeder.sv
// Packs a feature byte stream into two ping-pong banks, launches nn_engine on each full bank,
// serves the engine's feature reads and queues its results with a frame sequence number.
module nn_feature_feeder #(
    parameter int unsigned N_FEAT    = nn_pkg::N_FEAT,
    parameter int unsigned FEAT_W    = nn_pkg::FEAT_W,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_feat_valid,
    input  logic [FEAT_W-1:0]           i_feat_data,
    output logic                        o_feat_ready,
    output logic                        o_nn_start,
    input  logic [$clog2(N_FEAT)-1:0]   i_nn_feature_addr,
    output logic [FEAT_W-1:0]           o_nn_feature_in,
    input  logic                        i_nn_busy,
    input  logic                        i_nn_done,
    input  logic [nn_pkg::CLASS_W-1:0]  i_nn_class_id,
    input  logic [nn_pkg::CONF_W-1:0]   i_nn_confidence,
    input  logic                        i_wt_wr_en,
    output logic                        o_res_valid,
    input  logic                        i_res_ready,
    output logic [nn_pkg::CLASS_W-1:0]  o_res_class,
    output logic [nn_pkg::CONF_W-1:0]   o_res_conf,
    output logic [nn_pkg::SEQ_W-1:0]    o_res_seq,
    output logic [7:0]                  o_drop_cnt
);

    import nn_pkg::*;

    localparam int unsigned AW = $clog2(N_FEAT);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_FEAT - 1);

    logic [FEAT_W-1:0] r_bank [2][N_FEAT];
    logic [1:0]        r_bank_full;
    logic [1:0]        w_bank_full_d;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [AW-1:0]     r_wr_idx;
    feeder_state_e     r_state;
    feeder_state_e     w_state_d;
    logic              r_start;
    logic [SEQ_W-1:0]  r_seq;
    logic [7:0]        r_drop_cnt;

    logic              w_wr_hs;
    logic              w_wr_last;
    logic              w_done_run;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    nn_result_t        w_push_res;
    nn_result_t        w_head_res;

    assign o_feat_ready    = !r_bank_full[r_wr_bank];
    assign w_wr_hs         = i_feat_valid && o_feat_ready;
    assign w_wr_last       = (r_wr_idx == LAST_IDX);
    assign w_done_run      = (r_state == StRun) && i_nn_done;
    assign o_nn_feature_in = r_bank[r_rd_bank][i_nn_feature_addr];
    assign o_nn_start      = r_start;

    // Filling one bank and releasing the other may coincide; they never target the same bank.
    always_comb begin
        w_bank_full_d = r_bank_full;
        if (w_done_run) begin
            w_bank_full_d[r_rd_bank] = 1'b0;
        end
        if (w_wr_hs && w_wr_last) begin
            w_bank_full_d[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < N_FEAT; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
        end else if (w_wr_hs) begin
            r_bank[r_wr_bank][r_wr_idx] <= i_feat_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bank_full <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
        end else begin
            r_bank_full <= w_bank_full_d;
            if (w_wr_hs) begin
                r_wr_idx <= w_wr_last ? '0 : r_wr_idx + AW'(1);
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_done_run) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // A start the engine ignores (busy never rises) falls back to idle and is retried.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (r_bank_full[r_rd_bank] && !i_nn_busy && !i_wt_wr_en) begin
                    w_state_d = StStart;
                end
            end
            StStart: w_state_d = StAck;
            StAck:   w_state_d = i_nn_busy ? StRun : StIdle;
            StRun: begin
                if (i_nn_done) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_start <= (w_state_d == StStart);
        end
    end

    assign w_push_res = {i_nn_class_id, i_nn_confidence, r_seq};
    assign w_pop      = !w_fifo_empty && i_res_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq      <= '0;
            r_drop_cnt <= '0;
        end else if (w_done_run) begin
            r_seq <= r_seq + SEQ_W'(1);
            if (w_fifo_full && !w_pop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    nn_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH ($bits(nn_result_t))
    ) u_res_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_done_run),
        .i_data  (w_push_res),
        .i_pop   (w_pop),
        .o_head  (w_head_res),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_res_valid = !w_fifo_empty;
    assign o_res_class = w_head_res.cls;
    assign o_res_conf  = w_head_res.conf;
    assign o_res_seq   = w_head_res.seq;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_nn_feature_feeder.sv
// Bench for nn_feature_feeder: random feature frames, a behavioural engine and a queue-based
// reference for frame contents, result ordering, sequence numbers and drop counting.
module tb_nn_feature_feeder;

    localparam int NF    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] cls;
        logic [7:0] conf;
        logic [3:0] seq;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       feat_valid = 1'b0;
    logic [7:0] feat_data = '0;
    logic       feat_ready;
    logic       nn_start;
    logic [2:0] nn_addr;
    logic [7:0] nn_feat;
    logic       nn_busy;
    logic       nn_done;
    logic [1:0] nn_class;
    logic [7:0] nn_conf;
    logic       wt_wr_en = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [1:0] res_class;
    logic [7:0] res_conf;
    logic [3:0] res_seq;
    logic [7:0] drop_cnt;

    nn_feature_feeder #(
        .N_FEAT    (NF),
        .FEAT_W    (8),
        .RES_DEPTH (DEPTH)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_feat_valid      (feat_valid),
        .i_feat_data       (feat_data),
        .o_feat_ready      (feat_ready),
        .o_nn_start        (nn_start),
        .i_nn_feature_addr (nn_addr),
        .o_nn_feature_in   (nn_feat),
        .i_nn_busy         (nn_busy),
        .i_nn_done         (nn_done),
        .i_nn_class_id     (nn_class),
        .i_nn_confidence   (nn_conf),
        .i_wt_wr_en        (wt_wr_en),
        .o_res_valid       (res_valid),
        .i_res_ready       (res_ready),
        .o_res_class       (res_class),
        .o_res_conf        (res_conf),
        .o_res_seq         (res_seq),
        .o_drop_cnt        (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    res_t        exp_q[$];
    logic [63:0] frame_q[$];
    logic [63:0] cur_frame = '0;
    int          cur_n = 0;
    int          ref_seq = 0;
    int          drop_exp = 0;

    // Engine model controls.
    int         eng_lat = 5;
    int         eng_ignore = 0;
    bit         eng_hold = 0;
    bit         eng_noref = 0;
    bit         eng_fixed = 0;
    logic [1:0] fix_cls = '0;
    logic [7:0] fix_conf = '0;
    int         eng_done_cnt = 0;
    logic [7:0] eng_feat [NF];

    int start_cnt = 0;
    int start_multi = 0;
    bit prev_start = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_ref();
        exp_q.delete();
        frame_q.delete();
        cur_n = 0;
        ref_seq = 0;
        drop_exp = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        feat_valid = 1'b0;
        wt_wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_ref();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        bit taken = 0;
        feat_valid = 1'b1;
        feat_data = b;
        waited = 0;
        while (!taken) begin
            @(negedge clk);
            if (feat_ready === 1'b1) begin
                @(posedge clk);
                #1;
                cur_frame[cur_n*8 +: 8] = b;
                cur_n++;
                if (cur_n == NF) begin
                    frame_q.push_back(cur_frame);
                    cur_n = 0;
                end
                taken = 1;
            end else begin
                @(posedge clk);
                #1;
                waited++;
                if (waited > 3000) begin
                    check_eq("send_timeout", waited, 0);
                    taken = 1;
                end
            end
        end
    endtask

    task automatic send_random(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            send_byte(8'($urandom), w);
        end
        feat_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (eng_done_cnt < target && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 64'(eng_done_cnt >= target), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_engine();
        logic [63:0] got;
        int          sum = 0;
        int          guard = 0;
        res_t        r;
        @(posedge clk);
        #1;
        nn_busy = 1'b1;
        for (int i = 0; i < NF; i++) begin
            nn_addr = 3'(i);
            #1;
            eng_feat[i] = nn_feat;
            got[i*8 +: 8] = nn_feat;
            sum += int'(nn_feat);
        end
        check_eq("eng_frame_avail", 64'(frame_q.size() > 0), 64'd1);
        if (frame_q.size() > 0) begin
            check_eq("eng_frame_data", got, frame_q.pop_front());
        end
        repeat (eng_lat) @(posedge clk);
        #1;
        while (eng_hold && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        nn_class = eng_fixed ? fix_cls : 2'(sum);
        nn_conf  = eng_fixed ? fix_conf : (8'(sum) ^ 8'h3C);
        nn_done  = 1'b1;
        if (!eng_noref) begin
            r.cls  = nn_class;
            r.conf = nn_conf;
            r.seq  = 4'(ref_seq);
            ref_seq++;
            if (exp_q.size() < DEPTH) exp_q.push_back(r);
            else drop_exp++;
        end
        @(posedge clk);
        #1;
        nn_done = 1'b0;
        nn_busy = 1'b0;
        nn_addr = '0;
        eng_done_cnt++;
    endtask

    initial begin : engine
        nn_busy = 1'b0;
        nn_done = 1'b0;
        nn_addr = '0;
        nn_class = '0;
        nn_conf = '0;
        forever begin
            @(posedge clk);
            #1;
            if (nn_start === 1'b1) begin
                if (eng_ignore > 0) eng_ignore--;
                else run_engine();
            end
        end
    end

    initial begin : consumer
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_ready && res_valid === 1'b1) begin
                check_eq("res_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("res_head", {res_class, res_conf, res_seq}, e);
                end
            end
        end
    end

    initial begin : start_mon
        forever begin
            @(negedge clk);
            if (nn_start === 1'b1) begin
                start_cnt++;
                if (prev_start) start_multi++;
            end
            prev_start = (nn_start === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w, first_stall, done_at, s0, n, base;

        // 1: single frame, start timing, feature read, fixed result
        do_reset();
        check_eq("rst_start", nn_start, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_ready", feat_ready, 1);
        eng_fixed = 1;
        fix_cls = 2'd2;
        fix_conf = 8'h5A;
        eng_lat = 5;
        s0 = start_cnt;
        for (int i = 0; i < NF; i++) send_byte(8'(i + 1), w);
        feat_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_start_e0", nn_start, 0);
        @(negedge clk);
        check_eq("t1_start_e1", nn_start, 1);
        @(negedge clk);
        check_eq("t1_start_e2", nn_start, 0);
        wait_done(eng_done_cnt + 1, "t1_done");
        check_eq("t1_addr3", eng_feat[3], 8'd4);
        @(negedge clk);
        check_eq("t1_res_valid", res_valid, 1);
        check_eq("t1_res_class", res_class, 2);
        check_eq("t1_res_conf", res_conf, 8'h5A);
        check_eq("t1_res_seq", res_seq, 0);
        check_eq("t1_start_pulses", start_cnt - s0, 1);
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        eng_fixed = 0;

        // 2: back-pressure with a slow engine
        do_reset();
        eng_lat = 200;
        first_stall = -1;
        done_at = -1;
        base = eng_done_cnt;
        for (int k = 0; k < 24; k++) begin
            send_byte(8'($urandom), w);
            if (w > 0 && first_stall < 0) begin
                first_stall = k;
                done_at = eng_done_cnt - base;
            end
        end
        feat_valid = 1'b0;
        check_eq("t2_first_stall", first_stall, 16);
        check_eq("t2_done_before_17", done_at, 1);
        wait_done(base + 3, "t2_done");
        check_eq("t2_drop", drop_cnt, drop_exp);
        check_eq("t2_drained", exp_q.size(), 0);

        // 3: weight write inhibits launch
        do_reset();
        eng_lat = 5;
        wt_wr_en = 1'b1;
        s0 = start_cnt;
        send_random(NF);
        repeat (50) @(posedge clk);
        #1;
        check_eq("t3_no_start", start_cnt - s0, 0);
        wt_wr_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (nn_start !== 1'b1 && n < 10);
        check_eq("t3_start_delay", n, 2);
        wait_done(eng_done_cnt + 1, "t3_done");

        // 4: first start ignored, retried with the same bank
        do_reset();
        eng_ignore = 1;
        s0 = start_cnt;
        base = eng_done_cnt;
        send_random(NF);
        wait_done(base + 1, "t4_done");
        check_eq("t4_start_pulses", start_cnt - s0, 2);
        check_eq("t4_ignored", eng_ignore, 0);

        // 5: FIFO overflow without pops, then ordered drain
        do_reset();
        res_ready = 1'b0;
        eng_lat = 3;
        base = eng_done_cnt;
        send_random(6 * NF);
        wait_done(base + 6, "t5_done");
        check_eq("t5_drop_model", drop_cnt, drop_exp);
        check_eq("t5_drop_two", drop_cnt, 2);
        check_eq("t5_held", exp_q.size(), DEPTH);
        check_eq("t5_res_valid", res_valid, 1);
        res_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_eq("t5_empty", res_valid, 0);
        check_eq("t5_drained", exp_q.size(), 0);

        // 7: drop counter saturation and sequence wrap
        do_reset();
        res_ready = 1'b0;
        eng_lat = 1;
        base = eng_done_cnt;
        send_random(260 * NF);
        wait_done(base + 260, "t7_done");
        check_eq("t7_drop_sat", drop_cnt, (drop_exp > 255) ? 255 : drop_exp);
        res_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        base = eng_done_cnt;
        send_random(NF);
        wait_done(base + 1, "t7_wrap_done");
        check_eq("t7_drained", exp_q.size(), 0);

        // 6: asynchronous reset mid-run, late done ignored
        do_reset();
        res_ready = 1'b0;
        eng_lat = 2;
        base = eng_done_cnt;
        send_random(NF);
        wait_done(base + 1, "t6_first_done");
        eng_hold = 1;
        send_random(NF);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t6_busy", nn_busy, 1);
        send_random(3);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_start", nn_start, 0);
        check_eq("t6_rst_res_valid", res_valid, 0);
        clear_ref();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("t6_ready", feat_ready, 1);
        check_eq("t6_drop", drop_cnt, 0);
        s0 = start_cnt;
        eng_noref = 1;
        eng_hold = 0;
        wait_done(base + 2, "t6_late_done");
        check_eq("t6_late_ignored", res_valid, 0);
        check_eq("t6_no_start", start_cnt - s0, 0);
        eng_noref = 0;
        res_ready = 1'b1;
        send_random(NF);
        wait_done(base + 3, "t6_after_done");
        check_eq("t6_drained", exp_q.size(), 0);

        check_eq("start_width", start_multi, 0);
        check_eq("frames_left", frame_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
